// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control sequencer: aluc encodings,
// command opcodes, FSM states and the carry-in source select.
package alu_pkg;

  localparam logic [3:0] ALUC_PASS_A = 4'b0000;
  localparam logic [3:0] ALUC_PASS_B = 4'b0001;
  localparam logic [3:0] ALUC_NOT_A  = 4'b0010;
  localparam logic [3:0] ALUC_NOT_B  = 4'b0011;
  localparam logic [3:0] ALUC_ADD    = 4'b0100;
  localparam logic [3:0] ALUC_ADC    = 4'b0101;
  localparam logic [3:0] ALUC_OR     = 4'b0110;
  localparam logic [3:0] ALUC_AND    = 4'b0111;
  localparam logic [3:0] ALUC_ZERO   = 4'b1000;
  localparam logic [3:0] ALUC_ONE    = 4'b1001;
  localparam logic [3:0] ALUC_ONES   = 4'b1010;
  localparam logic [3:0] ALUC_CLC    = 4'b1011;
  localparam logic [3:0] ALUC_STC    = 4'b1100;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADC  = 3'b010,
    OP_OR   = 3'b011,
    OP_AND  = 3'b100,
    OP_NOT  = 3'b101,
    OP_CLC  = 3'b110,
    OP_STC  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CYS_ZERO = 2'd0,
    CYS_CY   = 2'd1,
    CYS_CLO  = 2'd2
  } cy_sel_t;

  function automatic logic is_single_pass(op_t op);
    return (op == OP_CLC) || (op == OP_STC);
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Bundle between decoder (command/response), the ALU and the sequencer.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the sender holds valid and payload stable until that edge.
interface alu_ctrl_if #(parameter int W = 16);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_op;
  logic [2*W-1:0] cmd_opnd;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [3:0]     alu_aluc;
  logic           alu_cy_in;
  logic [W-1:0]   alu_z;
  logic           alu_cy_out;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_acc;
  logic           rsp_cy;

  modport master (
    output cmd_valid, cmd_op, cmd_opnd, rsp_ready, alu_z, alu_cy_out,
    input  cmd_ready, alu_a, alu_b, alu_aluc, alu_cy_in, rsp_valid, rsp_acc, rsp_cy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_opnd, rsp_ready, alu_z, alu_cy_out,
    output cmd_ready, alu_a, alu_b, alu_aluc, alu_cy_in, rsp_valid, rsp_acc, rsp_cy
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Pass decoder: maps latched opcode and pass (lo/hi) to the ALU control word,
// carry-in source and the accumulator / carry write enables.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  op_t         op,
  input  logic        hi,
  output logic [3:0]  aluc,
  output cy_sel_t     cy_sel,
  output logic        acc_we,
  output logic        cy_we,
  output logic        clo_we
);
  logic cy_cap;

  always_comb begin
    aluc   = ALUC_PASS_A;
    cy_sel = CYS_ZERO;
    acc_we = 1'b1;
    unique case (op)
      OP_LOAD: aluc = ALUC_PASS_B;
      OP_ADD: begin
        aluc   = hi ? ALUC_ADC : ALUC_ADD;
        cy_sel = hi ? CYS_CLO : CYS_ZERO;
      end
      OP_ADC: begin
        aluc   = ALUC_ADC;
        cy_sel = hi ? CYS_CLO : CYS_CY;
      end
      OP_OR:  aluc = ALUC_OR;
      OP_AND: aluc = ALUC_AND;
      OP_NOT: aluc = ALUC_NOT_A;
      OP_CLC: begin
        aluc   = ALUC_CLC;
        acc_we = 1'b0;
      end
      OP_STC: begin
        aluc   = ALUC_STC;
        acc_we = 1'b0;
      end
      default: acc_we = 1'b0;
    endcase
    // Carry out is meaningful only for the arithmetic and flag encodings.
    cy_cap = (aluc == ALUC_ADD) || (aluc == ALUC_ADC) ||
             (aluc == ALUC_CLC) || (aluc == ALUC_STC);
    cy_we  = cy_cap && (hi || is_single_pass(op));
    clo_we = cy_cap && !hi && !is_single_pass(op);
  end
endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle sequencer that runs 2W-bit accumulator commands through a W-bit
// ALU as a low pass then a high pass, and returns ACC/CY over a response port.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int W = 16
) (
  input  logic     clk,
  input  logic     reset,
  alu_ctrl_if.slave bus,
  output state_t   dbg_state
);
  state_t         state;
  op_t            op;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] opnd;
  logic           cy;
  logic           clo;

  logic           hi;
  logic           in_pass;
  logic [3:0]     dec_aluc;
  cy_sel_t        dec_cy_sel;
  logic           dec_acc_we;
  logic           dec_cy_we;
  logic           dec_clo_we;

  assign hi      = (state == S_HI);
  assign in_pass = (state == S_LO) || (state == S_HI);

  alu_ctrl_dec u_dec (
    .op     (op),
    .hi     (hi),
    .aluc   (dec_aluc),
    .cy_sel (dec_cy_sel),
    .acc_we (dec_acc_we),
    .cy_we  (dec_cy_we),
    .clo_we (dec_clo_we)
  );

  // ALU is combinational, so its drive follows the current pass directly.
  always_comb begin
    bus.alu_aluc  = ALUC_PASS_A;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_cy_in = 1'b0;
    if (in_pass) begin
      bus.alu_aluc = dec_aluc;
      bus.alu_a    = hi ? acc[2*W-1:W] : acc[W-1:0];
      bus.alu_b    = hi ? opnd[2*W-1:W] : opnd[W-1:0];
      unique case (dec_cy_sel)
        CYS_CY:  bus.alu_cy_in = cy;
        CYS_CLO: bus.alu_cy_in = clo;
        default: bus.alu_cy_in = 1'b0;
      endcase
    end
  end

  assign bus.cmd_ready = (state == S_IDLE) && !reset;
  assign bus.rsp_acc   = acc;
  assign bus.rsp_cy    = cy;
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      op            <= OP_LOAD;
      acc           <= '0;
      opnd          <= '0;
      cy            <= 1'b0;
      clo           <= 1'b0;
      bus.rsp_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op    <= op_t'(bus.cmd_op);
            opnd  <= bus.cmd_opnd;
            state <= S_LO;
          end
        end
        S_LO: begin
          if (dec_acc_we) acc[W-1:0] <= bus.alu_z;
          if (dec_clo_we) clo <= bus.alu_cy_out;
          if (dec_cy_we)  cy  <= bus.alu_cy_out;
          if (is_single_pass(op)) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
          end else begin
            state <= S_HI;
          end
        end
        S_HI: begin
          if (dec_acc_we) acc[2*W-1:W] <= bus.alu_z;
          if (dec_cy_we)  cy <= bus.alu_cy_out;
          state         <= S_RESP;
          bus.rsp_valid <= 1'b1;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural 16-bit ALU attached to the
// ALU side of the bus.
module tb_alu_ctrl;
  import alu_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg_state;
  int     checks;
  int     errors;

  alu_ctrl_if #(.W(16)) bus ();

  alu_ctrl #(.W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, actual time %0t, required < 300000", $time);
    $fatal(1, "watchdog");
  end

  // reference ALU
  logic [16:0] sum;
  always_comb begin
    sum            = '0;
    bus.alu_z      = '0;
    bus.alu_cy_out = 1'b0;
    case (bus.alu_aluc)
      4'd0:  bus.alu_z = bus.alu_a;
      4'd1:  bus.alu_z = bus.alu_b;
      4'd2:  bus.alu_z = ~bus.alu_a;
      4'd3:  bus.alu_z = ~bus.alu_b;
      4'd4: begin
        sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_z = sum[15:0];
        bus.alu_cy_out = sum[16];
      end
      4'd5: begin
        sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'd0, bus.alu_cy_in};
        bus.alu_z = sum[15:0];
        bus.alu_cy_out = sum[16];
      end
      4'd6:  bus.alu_z = bus.alu_a | bus.alu_b;
      4'd7:  bus.alu_z = bus.alu_a & bus.alu_b;
      4'd8:  bus.alu_z = 16'h0000;
      4'd9:  bus.alu_z = 16'h0001;
      4'd10: bus.alu_z = 16'hFFFF;
      4'd11: bus.alu_cy_out = 1'b0;
      4'd12: bus.alu_cy_out = 1'b1;
      default: bus.alu_z = 16'h0000;
    endcase
  end

  // driver: issue one command with rsp_ready high, record what was observed
  task automatic run_cmd(input logic [2:0] op, input logic [31:0] opnd,
                         output int lat, output logic [31:0] acc, output logic cy,
                         output logic [3:0] aluc_lo, output logic [3:0] aluc_hi,
                         output logic cyin_hi, output logic to);
    to = 1'b0; lat = 0; aluc_lo = '0; aluc_hi = '0; cyin_hi = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_opnd = opnd; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
    if (!bus.cmd_ready) to = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) aluc_lo = bus.alu_aluc;
      if (k == 2) begin aluc_hi = bus.alu_aluc; cyin_hi = bus.alu_cy_in; end
      if (bus.rsp_valid) begin lat = k; break; end
      @(negedge clk);
    end
    if (lat == 0) to = 1'b1;
    acc = bus.rsp_acc;
    cy  = bus.rsp_cy;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_acc !== 32'h0 || bus.rsp_cy !== 1'b0) begin errors++; $display("FAIL reset_acc_cy: got %h/%b want 0/0", bus.rsp_acc, bus.rsp_cy); end
    checks++; if (bus.alu_aluc !== 4'b0000 || bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0 || bus.alu_cy_in !== 1'b0) begin
      errors++; $display("FAIL reset_idle_drive: got aluc %b a %h b %h cyin %b want all 0", bus.alu_aluc, bus.alu_a, bus.alu_b, bus.alu_cy_in); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_load_add();
    int lat; logic [31:0] acc; logic cy; logic [3:0] alo, ahi; logic cin, to;
    run_cmd(3'b000, 32'h0001_FFFF, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (to !== 1'b0 || lat != 3) begin errors++; $display("FAIL load_latency: got %0d (timeout %b) want 3", lat, to); end
    checks++; if (acc !== 32'h0001_FFFF || cy !== 1'b0) begin errors++; $display("FAIL load_result: got %h/%b want 0001ffff/0", acc, cy); end
    checks++; if (alo !== 4'b0001 || ahi !== 4'b0001) begin errors++; $display("FAIL load_aluc: got %b/%b want 0001/0001", alo, ahi); end
    run_cmd(3'b001, 32'h0000_0001, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (to !== 1'b0 || lat != 3) begin errors++; $display("FAIL add_latency: got %0d (timeout %b) want 3", lat, to); end
    checks++; if (acc !== 32'h0002_0000 || cy !== 1'b0) begin errors++; $display("FAIL add_result: got %h/%b want 00020000/0", acc, cy); end
    checks++; if (alo !== 4'b0100 || ahi !== 4'b0101 || cin !== 1'b1) begin
      errors++; $display("FAIL add_passes: got lo %b hi %b cyin %b want 0100 0101 1", alo, ahi, cin); end
  endtask

  task automatic test_carry();
    int lat; logic [31:0] acc; logic cy; logic [3:0] alo, ahi; logic cin, to;
    run_cmd(3'b000, 32'hFFFF_FFFF, lat, acc, cy, alo, ahi, cin, to);
    run_cmd(3'b001, 32'h0000_0001, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (to !== 1'b0 || acc !== 32'h0 || cy !== 1'b1) begin errors++; $display("FAIL add_wrap: got %h/%b want 00000000/1", acc, cy); end
    run_cmd(3'b010, 32'h0000_0000, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (to !== 1'b0 || acc !== 32'h1 || cy !== 1'b0) begin errors++; $display("FAIL adc_carry_in: got %h/%b want 00000001/0", acc, cy); end
    checks++; if (alo !== 4'b0101 || ahi !== 4'b0101 || cin !== 1'b0) begin
      errors++; $display("FAIL adc_passes: got lo %b hi %b cyin %b want 0101 0101 0", alo, ahi, cin); end
  endtask

  task automatic test_flags();
    int lat; logic [31:0] acc; logic cy; logic [3:0] alo, ahi; logic cin, to;
    run_cmd(3'b000, 32'h0000_0005, lat, acc, cy, alo, ahi, cin, to);
    run_cmd(3'b111, 32'h1234_5678, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (to !== 1'b0 || lat != 2) begin errors++; $display("FAIL stc_latency: got %0d (timeout %b) want 2", lat, to); end
    checks++; if (acc !== 32'h5 || cy !== 1'b1 || alo !== 4'b1100) begin errors++; $display("FAIL stc_result: got %h/%b aluc %b want 00000005/1 1100", acc, cy, alo); end
    run_cmd(3'b010, 32'h0000_0000, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (to !== 1'b0 || acc !== 32'h6 || cy !== 1'b0) begin errors++; $display("FAIL adc_after_stc: got %h/%b want 00000006/0", acc, cy); end
    run_cmd(3'b111, 32'h0, lat, acc, cy, alo, ahi, cin, to);
    run_cmd(3'b110, 32'h0, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (to !== 1'b0 || lat != 2 || acc !== 32'h6 || cy !== 1'b0 || alo !== 4'b1011) begin
      errors++; $display("FAIL clc_result: got lat %0d %h/%b aluc %b want 2 00000006/0 1011", lat, acc, cy, alo); end
  endtask

  task automatic test_logic();
    int lat; logic [31:0] acc; logic cy; logic [3:0] alo, ahi; logic cin, to;
    run_cmd(3'b111, 32'h0, lat, acc, cy, alo, ahi, cin, to);
    run_cmd(3'b000, 32'h1234_5678, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (acc !== 32'h1234_5678 || cy !== 1'b1) begin errors++; $display("FAIL load_keeps_cy: got %h/%b want 12345678/1", acc, cy); end
    run_cmd(3'b011, 32'h0F0F_0000, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (acc !== 32'h1F3F_5678 || cy !== 1'b1 || alo !== 4'b0110) begin errors++; $display("FAIL or_result: got %h/%b aluc %b want 1f3f5678/1 0110", acc, cy, alo); end
    run_cmd(3'b100, 32'hFF00_FF00, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (acc !== 32'h1F00_5600 || cy !== 1'b1 || alo !== 4'b0111) begin errors++; $display("FAIL and_result: got %h/%b aluc %b want 1f005600/1 0111", acc, cy, alo); end
    run_cmd(3'b101, 32'hDEAD_BEEF, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (to !== 1'b0 || acc !== 32'hE0FF_A9FF || cy !== 1'b1 || alo !== 4'b0010) begin
      errors++; $display("FAIL not_result: got %h/%b aluc %b want e0ffa9ff/1 0010", acc, cy, alo); end
  endtask

  task automatic test_backpressure();
    int waited;
    int lat; logic [31:0] acc; logic cy; logic [3:0] alo, ahi; logic cin, to;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'b000; bus.cmd_opnd = 32'hA5A5_0F0F;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_op = 3'b001; bus.cmd_opnd = 32'h0000_0001;
    waited = 0;
    while (!bus.rsp_valid && waited < 10) begin @(negedge clk); waited++; end
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_rise: got %b want 1", bus.rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_acc !== 32'hA5A5_0F0F || bus.cmd_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid %b acc %h ready %b want 1 a5a50f0f 0", i, bus.rsp_valid, bus.rsp_acc, bus.cmd_ready); end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_early: got %b want 0", bus.cmd_ready); end
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_after_release: got ready %b valid %b want 1 0", bus.cmd_ready, bus.rsp_valid); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++; if (dbg_state !== S_LO) begin errors++; $display("FAIL bp_second_accept: got state %0d want %0d", dbg_state, S_LO); end
    waited = 0;
    while (!bus.rsp_valid && waited < 10) begin @(negedge clk); waited++; end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_acc !== 32'hA5A5_0F10) begin
      errors++; $display("FAIL bp_second_result: got valid %b acc %h want 1 a5a50f10", bus.rsp_valid, bus.rsp_acc); end
    @(posedge clk);
    run_cmd(3'b000, 32'h0, lat, acc, cy, alo, ahi, cin, to);
    checks++; if (to !== 1'b0 || acc !== 32'h0) begin errors++; $display("FAIL bp_cleanup: got %h (timeout %b) want 00000000", acc, to); end
  endtask

  task automatic test_back_to_back();
    int hs; int rs;
    hs = 0; rs = 0;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'b001; bus.cmd_opnd = 32'h0000_0001;
    for (int i = 0; i < 12; i++) begin
      if (bus.cmd_valid && bus.cmd_ready) hs++;
      if (bus.rsp_valid) rs++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    checks++; if (hs != 3 || rs != 3) begin errors++; $display("FAIL b2b_throughput: got %0d cmds %0d rsps want 3 3", hs, rs); end
    checks++; if (bus.rsp_acc !== 32'h3 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL b2b_result: got acc %h state %0d want 00000003 %0d", bus.rsp_acc, dbg_state, S_IDLE); end
  endtask

  task automatic test_reset_mid();
    int rises;
    int lat; logic [31:0] acc; logic cy; logic [3:0] alo, ahi; logic cin, to;
    run_cmd(3'b111, 32'h0, lat, acc, cy, alo, ahi, cin, to);
    run_cmd(3'b000, 32'h0001_0001, lat, acc, cy, alo, ahi, cin, to);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'b001; bus.cmd_opnd = 32'h0000_FFFF;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== S_HI) begin errors++; $display("FAIL mid_in_hi: got state %0d want %0d", dbg_state, S_HI); end
    reset = 1'b1;
    #1;
    checks++; if (bus.rsp_acc !== 32'h0 || bus.rsp_cy !== 1'b0 || dbg_state !== S_IDLE || bus.cmd_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_clear: got acc %h cy %b state %0d ready %b want 0 0 0 0", bus.rsp_acc, bus.rsp_cy, dbg_state, bus.cmd_ready); end
    @(negedge clk);
    reset = 1'b0;
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b want 1", bus.cmd_ready); end
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid) rises++;
      @(negedge clk);
    end
    checks++; if (rises != 0 || bus.rsp_acc !== 32'h0) begin errors++; $display("FAIL mid_no_response: got %0d valid cycles acc %h want 0 00000000", rises, bus.rsp_acc); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'b000; bus.cmd_opnd = '0; bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_load_add();
    test_carry();
    test_flags();
    test_logic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
